can_crc_ctrl: RTL and testbench

Sequencer for the CAN 15-bit CRC register. It clears the CRC at start of frame and feeds it every non-stuff bit up to the end of the data field. It then latches the result and serializes it into the CRC field: transmitted bits for TX, compared against received bits for RX. It sits between the bit-timing/frame FSM and the CRC register (`can_crc`), which it instantiates.

---
 rtl/can_crc_ctrl_pkg.sv | 22 ++
 rtl/can_crc_ctrl_if.sv | 36 +++
 rtl/can_crc_ctrl_crc.sv | 40 ++++
 rtl/can_crc_ctrl.sv | 127 ++++++++++++
 tb/tb_can_crc_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/can_crc_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : can_pkg                                                      |
// | Description : Shared CAN CRC constants and the CRC sequencer state type.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package can_pkg;

  localparam int          CAN_CRC_W    = 15;
  localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CALC      = 2'd1,
    CRC_FIELD = 2'd2,
    DONE      = 2'd3
  } crc_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/can_crc_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module      : can_crc_ctrl_if                                              |
// | Description : Frame-FSM <-> CRC sequencer strobes and status.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface can_crc_ctrl_if
  import can_pkg::*;
();

  logic                 sample_point;
  logic                 rx_bit;
  logic                 stuff_bit;
  logic                 sof;
  logic                 crc_start;
  logic                 abort;
  logic [CAN_CRC_W-1:0] crc_o;
  logic                 tx_bit_o;
  logic                 busy_o;
  logic                 crc_done_o;
  logic                 crc_err_o;

  modport master (
    output sample_point, rx_bit, stuff_bit, sof, crc_start, abort,
    input  crc_o, tx_bit_o, busy_o, crc_done_o, crc_err_o
  );

  modport slave (
    input  sample_point, rx_bit, stuff_bit, sof, crc_start, abort,
    output crc_o, tx_bit_o, busy_o, crc_done_o, crc_err_o
  );

endinterface

`default_nettype wire

// File: rtl/can_crc_ctrl_crc.sv
// +----------------------------------------------------------------------------+
// | Module      : can_crc                                                      |
// | Description : CAN CRC shift register, synchronous clear, one bit per enable|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module can_crc
  import can_pkg::*;
#(
  parameter int               CRC_W    = CAN_CRC_W,
  parameter logic [CRC_W-1:0] CRC_POLY = CAN_CRC_POLY
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             data_bit,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] r_crc;
  logic             w_feedback;
  logic [CRC_W-1:0] w_crc_next;

  assign w_feedback = data_bit ^ r_crc[CRC_W-1];
  assign w_crc_next = {r_crc[CRC_W-2:0], 1'b0} ^ (w_feedback ? CRC_POLY : '0);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_crc <= '0;
    end else if (enable) begin
      r_crc <= w_crc_next;
    end
  end

  assign crc_o = r_crc;

endmodule

`default_nettype wire

// File: rtl/can_crc_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : can_crc_ctrl                                                 |
// | Description : Clears/feeds the CAN CRC, then serializes and checks it.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module can_crc_ctrl
  import can_pkg::*;
#(
  parameter int               CRC_W    = CAN_CRC_W,
  parameter logic [CRC_W-1:0] CRC_POLY = CAN_CRC_POLY
) (
  input  logic        clk,
  input  logic        rst_n,
  can_crc_ctrl_if.slave bus
);

  crc_ctrl_state_t  r_state;
  logic [CRC_W-1:0] r_crc_sr;
  logic [3:0]       r_cnt;
  logic             r_tx_bit;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_rst_sync;
  logic [CRC_W-1:0] w_crc;
  logic             w_clear;
  logic             w_crc_en;
  logic             w_counted;

  // The CRC register only has a synchronous clear, so hold it cleared while
  // reset is asserted and for the first edges after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_counted = bus.sample_point & ~bus.stuff_bit;
  assign w_clear   = ~r_rst_sync[1]
                   | ((r_state == IDLE) & bus.sof & bus.sample_point & ~bus.abort);
  assign w_crc_en  = (r_state == CALC) & w_counted & ~bus.crc_start & ~bus.abort;

  can_crc #(
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY)
  ) u_crc (
    .clk      (clk),
    .clear    (w_clear),
    .enable   (w_crc_en),
    .data_bit (bus.rx_bit),
    .crc_o    (w_crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_crc_sr <= '0;
      r_cnt    <= 4'd0;
      r_tx_bit <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state  <= IDLE;
        r_tx_bit <= 1'b1;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.sof && bus.sample_point) begin
              r_state <= CALC;
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          CALC: begin
            if (bus.crc_start) begin
              r_state  <= CRC_FIELD;
              r_crc_sr <= w_crc;
              r_cnt    <= 4'd0;
              r_tx_bit <= w_crc[CRC_W-1];
            end
          end
          CRC_FIELD: begin
            if (w_counted) begin
              if (bus.rx_bit != r_crc_sr[CRC_W-1]) begin
                r_err <= 1'b1;
              end
              r_crc_sr <= {r_crc_sr[CRC_W-2:0], 1'b1};
              r_cnt    <= r_cnt + 4'd1;
              if (r_cnt == 4'(CRC_W - 1)) begin
                r_state  <= DONE;
                r_done   <= 1'b1;
                r_tx_bit <= 1'b1;
              end else begin
                r_tx_bit <= r_crc_sr[CRC_W-2];
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.crc_o      = w_crc;
  assign bus.tx_bit_o   = r_tx_bit;
  assign bus.busy_o     = r_busy;
  assign bus.crc_done_o = r_done;
  assign bus.crc_err_o  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_can_crc_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_can_crc_ctrl                                              |
// | Description : Directed frames against a polynomial-division CRC model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_can_crc_ctrl;
  import can_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  can_crc_ctrl_if bus ();

  can_crc_ctrl #(
    .CRC_W    (CAN_CRC_W),
    .CRC_POLY (CAN_CRC_POLY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // CRC as the remainder of M(x)*x^15 divided by the full 16-bit generator.
  function automatic logic [14:0] crc_of(input bit q[$]);
    logic [15:0] rem;
    bit          b;
    rem = '0;
    for (int i = 0; i < q.size() + 15; i++) begin
      b   = (i < q.size()) ? q[i] : 1'b0;
      rem = {rem[14:0], b};
      if (rem[15]) rem = rem ^ 16'hC599;
    end
    return rem[14:0];
  endfunction

  int          m_phase = 0;
  bit          m_data[$];
  logic [14:0] m_crc = '0;
  logic [14:0] m_sr  = '0;
  int          m_idx = 0;
  logic        m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  bit          m_crc_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_data.delete();
      if (clk) begin
        m_crc = '0; m_crc_valid = 1'b1;
      end else begin
        m_crc_valid = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (bus.abort) begin
        m_phase = 0; m_tx = 1'b1; m_busy = 1'b0;
      end else begin
        case (m_phase)
          0: if (bus.sof && bus.sample_point) begin
               m_phase = 1; m_data.delete(); m_crc = crc_of(m_data);
               m_err = 1'b0; m_busy = 1'b1;
             end
          1: if (bus.crc_start) begin
               m_phase = 2; m_sr = m_crc; m_idx = 0; m_tx = m_sr[14];
             end else if (bus.sample_point && !bus.stuff_bit) begin
               m_data.push_back(bus.rx_bit);
               m_crc = crc_of(m_data);
             end
          2: if (bus.sample_point && !bus.stuff_bit) begin
               if (bus.rx_bit != m_sr[14 - m_idx]) m_err = 1'b1;
               m_idx++;
               if (m_idx == 15) begin
                 m_phase = 3; m_done = 1'b1; m_tx = 1'b1;
               end else begin
                 m_tx = m_sr[14 - m_idx];
               end
             end
          default: begin
            m_phase = 0; m_busy = 1'b0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_bit_o",   32'(bus.tx_bit_o),   32'(m_tx));
      check("busy_o",     32'(bus.busy_o),     32'(m_busy));
      check("crc_done_o", 32'(bus.crc_done_o), 32'(m_done));
      check("crc_err_o",  32'(bus.crc_err_o),  32'(m_err));
      if (m_crc_valid) check("crc_o", 32'(bus.crc_o), 32'(m_crc));
    end
  end

  task automatic sample(input logic rx, input logic st, output logic d1, output logic e1);
    bus.sample_point = 1'b1; bus.rx_bit = rx; bus.stuff_bit = st;
    @(negedge clk);
    d1 = bus.crc_done_o; e1 = bus.crc_err_o;
    bus.sample_point = 1'b0; bus.stuff_bit = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_sof();
    bus.sof = 1'b1; bus.sample_point = 1'b1; bus.rx_bit = 1'b0;
    @(negedge clk);
    bus.sof = 1'b0; bus.sample_point = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_crc_start();
    bus.crc_start = 1'b1;
    @(negedge clk);
    bus.crc_start = 1'b0;
  endtask

  // Echoes tx_bit_o back as rx_bit, optionally inverting one bit and
  // inserting stuff bits (of opposite value) before counted bits 5 and 10.
  task automatic crc_field(input int n, input int flip_idx, input bit with_stuff,
                           output logic [14:0] txw, output logic d_last,
                           output logic e_last, output logic e_at_flip);
    logic b, d, e;
    txw = '0; d_last = 1'b0; e_last = 1'b0; e_at_flip = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (with_stuff && (k == 5 || k == 10)) begin
        b = bus.tx_bit_o;
        sample(~b, 1'b1, d, e);
      end
      b   = bus.tx_bit_o;
      txw = {txw[13:0], b};
      sample(b ^ logic'(k == flip_idx), 1'b0, d, e);
      if (k == flip_idx) e_at_flip = e;
      d_last = d; e_last = e;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        d, e, ef;
    logic [14:0] txw;
    bit          q[$];

    bus.sample_point = 1'b0; bus.rx_bit = 1'b0; bus.stuff_bit = 1'b0;
    bus.sof = 1'b0; bus.crc_start = 1'b0; bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx",   32'(bus.tx_bit_o),   32'd1);
    check("reset_busy", 32'(bus.busy_o),     32'd0);
    check("reset_done", 32'(bus.crc_done_o), 32'd0);
    check("reset_err",  32'(bus.crc_err_o),  32'd0);
    check("reset_crc",  32'(bus.crc_o),      32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    q = {1'b1};
    check("model_crc_1", 32'(crc_of(q)), 32'h4599);
    q.push_back(1'b0);
    check("model_crc_10", 32'(crc_of(q)), 32'h4EAB);

    // Clean frame, data 1,0, echoed CRC field
    do_sof();
    sample(1'b1, 1'b0, d, e);
    check("f1_crc_bit1", 32'(bus.crc_o), 32'h4599);
    sample(1'b0, 1'b0, d, e);
    check("f1_crc_bit2", 32'(bus.crc_o), 32'h4EAB);
    do_crc_start();
    crc_field(15, -1, 1'b0, txw, d, e, ef);
    check("f1_tx_seq", 32'(txw), 32'(15'b100111010101011));
    check("f1_done",   32'(d), 32'd1);
    check("f1_err",    32'(e), 32'd0);
    check("f1_idle_busy", 32'(bus.busy_o), 32'd0);

    // 4th CRC-field bit inverted
    do_sof();
    sample(1'b1, 1'b0, d, e);
    sample(1'b0, 1'b0, d, e);
    do_crc_start();
    crc_field(15, 3, 1'b0, txw, d, e, ef);
    check("f2_err_at_flip", 32'(ef), 32'd1);
    check("f2_done",        32'(d),  32'd1);
    check("f2_err_at_done", 32'(e),  32'd1);

    // Stuff bit between data bits, two stuff bits inside the CRC field
    do_sof();
    sample(1'b1, 1'b0, d, e);
    sample(1'b1, 1'b1, d, e);
    sample(1'b0, 1'b0, d, e);
    check("f3_crc", 32'(bus.crc_o), 32'h4EAB);
    do_crc_start();
    crc_field(15, -1, 1'b1, txw, d, e, ef);
    check("f3_tx_seq", 32'(txw), 32'h4EAB);
    check("f3_done",   32'(d),   32'd1);
    check("f3_err",    32'(e),   32'd0);

    // Abort after 7 CRC-field bits
    do_sof();
    sample(1'b1, 1'b0, d, e);
    sample(1'b0, 1'b0, d, e);
    do_crc_start();
    crc_field(7, -1, 1'b0, txw, d, e, ef);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy_o),     32'd0);
    check("abort_tx",   32'(bus.tx_bit_o),   32'd1);
    check("abort_done", 32'(bus.crc_done_o), 32'd0);
    check("abort_crc_held", 32'(bus.crc_o),  32'h4EAB);
    repeat (4) @(negedge clk);
    do_sof();
    sample(1'b1, 1'b0, d, e);
    check("post_abort_crc1", 32'(bus.crc_o), 32'h4599);
    sample(1'b0, 1'b0, d, e);
    do_crc_start();
    crc_field(15, -1, 1'b0, txw, d, e, ef);
    check("post_abort_done", 32'(d), 32'd1);

    // crc_start coincident with the second data sample
    do_sof();
    sample(1'b1, 1'b0, d, e);
    bus.sample_point = 1'b1; bus.rx_bit = 1'b0; bus.crc_start = 1'b1;
    @(negedge clk);
    bus.sample_point = 1'b0; bus.crc_start = 1'b0;
    @(negedge clk);
    check("coinc_crc", 32'(bus.crc_o), 32'h4599);
    crc_field(15, -1, 1'b0, txw, d, e, ef);
    check("coinc_sr",   32'(txw), 32'h4599);
    check("coinc_done", 32'(d),   32'd1);

    // Reset asserted mid CRC field with the error flag set
    do_sof();
    sample(1'b1, 1'b0, d, e);
    sample(1'b0, 1'b0, d, e);
    do_crc_start();
    crc_field(5, 1, 1'b0, txw, d, e, ef);
    check("rst_pre_err", 32'(e), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx",   32'(bus.tx_bit_o),   32'd1);
    check("rst_async_busy", 32'(bus.busy_o),     32'd0);
    check("rst_async_done", 32'(bus.crc_done_o), 32'd0);
    check("rst_async_err",  32'(bus.crc_err_o),  32'd0);
    @(negedge clk);
    check("rst_crc_in_reset", 32'(bus.crc_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_crc_after_release", 32'(bus.crc_o), 32'd0);
    repeat (3) @(negedge clk);

    do_sof();
    sample(1'b1, 1'b0, d, e);
    sample(1'b0, 1'b0, d, e);
    check("post_rst_crc", 32'(bus.crc_o), 32'h4EAB);
    do_crc_start();
    crc_field(15, -1, 1'b0, txw, d, e, ef);
    check("post_rst_done", 32'(d), 32'd1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
